// File: rtl/ble_usb_pkg.sv
// Shared types for the BLE-analyser-to-USB output stage: output FSM states,
// committed-packet descriptor layout and fixed field widths.
package ble_usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LEN,
    HDR_RSSI,
    HDR_CHAN,
    PAYLOAD
  } out_state_e;

  localparam int HDR_WORDS    = 3;
  localparam int DROP_CNT_W   = 16;
  // Descriptor fields are stored wide enough for any supported header width
  // and zero-extended/truncated to DATA_W on the way out.
  localparam int DESC_FIELD_W = 16;

  typedef struct packed {
    logic [DESC_FIELD_W-1:0] len;
    logic [DESC_FIELD_W-1:0] rssi;
    logic [DESC_FIELD_W-1:0] channel;
  } desc_t;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO with a speculative write pointer: writes become visible to
// the reader only on commit, and rollback discards everything uncommitted.
module commit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         commit,
  input  logic         rollback,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full_spec,
  output logic         full_com
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] wr_spec_q;
  logic [PW-1:0] wr_com_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] base;
  logic [PW-1:0] spec_nxt;
  logic          wr_ok;
  logic          rd_ok;
  logic [W-1:0]  mem [DEPTH];

  // Rollback takes effect before this cycle's write, so a restarting packet
  // lands its first word at the committed pointer.
  assign base      = rollback ? wr_com_q : wr_spec_q;
  assign wr_ok     = wr_en && ((base - rd_q) != DEPTH_P);
  assign spec_nxt  = base + PW'(wr_ok);
  assign empty     = (rd_q == wr_com_q);
  assign rd_ok     = rd_en && !empty;
  assign full_spec = ((wr_spec_q - rd_q) == DEPTH_P);
  assign full_com  = ((wr_com_q - rd_q) == DEPTH_P);
  assign rd_data   = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[base[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_spec_q <= '0;
      wr_com_q  <= '0;
      rd_q      <= '0;
    end else begin
      wr_spec_q <= spec_nxt;
      if (commit) wr_com_q <= spec_nxt;
      if (rd_ok)  rd_q     <= rd_q + PW'(1);
    end
  end

endmodule

// File: rtl/usb_frame_packer.sv
// Output stage between the BLE packet analyser and USB: buffers packets with
// commit/rollback and emits each committed packet as a len/rssi/chan/payload frame.
module usb_frame_packer
  import ble_usb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int RSSI_W     = 8,
  parameter int CHANNEL_W  = 7,
  parameter int MAX_LEN    = 64,
  parameter int BUF_DEPTH  = 256,
  parameter int DESC_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [DATA_W-1:0]     in_data_i,
  input  logic                  in_sop_i,
  input  logic                  in_eop_i,
  input  logic                  in_abort_i,
  input  logic [RSSI_W-1:0]     rssi_i,
  input  logic [CHANNEL_W-1:0]  channel_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  valid_o,
  output logic                  frame_o,
  input  logic                  ready_i,
  output logic                  pkt_dropped_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = LEN_W + 1;
  // Length counter sticks here once a packet is known to be too long.
  localparam logic [CNT_W-1:0] LEN_LIMIT = CNT_W'(MAX_LEN + 1);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic                  pkt_open;
  logic                  pkt_ovf;
  logic [CNT_W-1:0]      pkt_len;
  logic [RSSI_W-1:0]     rssi_q;
  logic [CHANNEL_W-1:0]  chan_q;
  logic                  drop_p1;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic             sop_v;
  logic             accept;
  logic             restart;
  logic             eop_v;
  logic             ovf_now;
  logic             commit_ok;
  logic             drop;
  logic [CNT_W-1:0] len_base;
  logic [CNT_W-1:0] len_now;

  logic              buf_wr;
  logic              buf_rb;
  logic              buf_rd;
  logic              buf_full;
  logic              buf_full_spec;
  logic              buf_full_com;
  logic [DATA_W-1:0] buf_rd_data;
  logic              unused_buf_empty;

  desc_t desc_in;
  desc_t desc_q;
  logic  desc_rd;
  logic  desc_empty;
  logic  desc_full;
  logic  unused_desc_full_com;

  out_state_e       state_q;
  out_state_e       state_d;
  logic [CNT_W-1:0] pay_cnt_q;

  // Stage p0: classify the incoming word against the open packet
  always_comb begin
    sop_v     = in_valid_i && in_sop_i;
    restart   = in_abort_i || (sop_v && pkt_open);
    accept    = in_valid_i && (in_sop_i || (pkt_open && !in_abort_i));
    eop_v     = accept && in_eop_i;
    len_base  = sop_v ? '0 : pkt_len;
    len_now   = (len_base == LEN_LIMIT) ? LEN_LIMIT : len_base + CNT_W'(1);
    buf_full  = restart ? buf_full_com : buf_full_spec;
    ovf_now   = (!sop_v && pkt_ovf) || (accept && buf_full);
    commit_ok = eop_v && (len_now <= CNT_W'(MAX_LEN)) && !ovf_now && !desc_full;
    drop      = eop_v && !commit_ok;
    buf_wr    = accept && !buf_full && !drop;
    buf_rb    = restart || drop;

    desc_in         = '0;
    desc_in.len     = DESC_FIELD_W'(len_now);
    desc_in.rssi    = DESC_FIELD_W'(sop_v ? rssi_i : rssi_q);
    desc_in.channel = DESC_FIELD_W'(sop_v ? channel_i : chan_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pkt_open <= 1'b0;
      pkt_ovf  <= 1'b0;
      pkt_len  <= '0;
      drop_p1  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) begin
        pkt_open <= !in_eop_i;
        pkt_len  <= len_now;
        pkt_ovf  <= ovf_now;
      end else if (in_abort_i) begin
        pkt_open <= 1'b0;
      end
      drop_p1 <= drop;
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (sop_v) begin
      rssi_q <= rssi_i;
      chan_q <= channel_i;
    end
  end

  assign pkt_dropped_o = drop_p1;
  assign drop_cnt_o    = drop_cnt;

  commit_fifo #(
    .W     (DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_payload_buf (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .wr_en     (buf_wr),
    .wr_data   (in_data_i),
    .commit    (commit_ok),
    .rollback  (buf_rb),
    .rd_en     (buf_rd),
    .rd_data   (buf_rd_data),
    .empty     (unused_buf_empty),
    .full_spec (buf_full_spec),
    .full_com  (buf_full_com)
  );

  commit_fifo #(
    .W     ($bits(desc_t)),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .wr_en     (commit_ok),
    .wr_data   (desc_in),
    .commit    (1'b1),
    .rollback  (1'b0),
    .rd_en     (desc_rd),
    .rd_data   (desc_q),
    .empty     (desc_empty),
    .full_spec (desc_full),
    .full_com  (unused_desc_full_com)
  );

  // Stage p1: frame emission; data_o is held by state and read pointers while stalled
  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    frame_o = 1'b0;
    data_o  = '0;
    buf_rd  = 1'b0;
    desc_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (!desc_empty) state_d = HDR_LEN;
      end
      HDR_LEN: begin
        valid_o = 1'b1;
        frame_o = 1'b1;
        data_o  = DATA_W'(desc_q.len);
        if (ready_i) state_d = HDR_RSSI;
      end
      HDR_RSSI: begin
        valid_o = 1'b1;
        frame_o = 1'b1;
        data_o  = DATA_W'(desc_q.rssi);
        if (ready_i) state_d = HDR_CHAN;
      end
      HDR_CHAN: begin
        valid_o = 1'b1;
        frame_o = 1'b1;
        data_o  = DATA_W'(desc_q.channel);
        if (ready_i) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        valid_o = 1'b1;
        frame_o = 1'b1;
        data_o  = buf_rd_data;
        if (ready_i) begin
          buf_rd = 1'b1;
          if (pay_cnt_q == CNT_W'(1)) begin
            desc_rd = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      pay_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == HDR_CHAN && ready_i) pay_cnt_q <= CNT_W'(desc_q.len);
      else if (buf_rd)                    pay_cnt_q <= pay_cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_usb_frame_packer.sv
// Directed bench for usb_frame_packer: framing, stalls, drops, aborts,
// descriptor-full drops and mid-frame reset.
`timescale 1ns/1ps
module tb_usb_frame_packer;
  import ble_usb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        in_abort = 1'b0;
  logic [7:0]  rssi = '0;
  logic [6:0]  channel = '0;
  logic        ready_i = 1'b1;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        frame_o;
  logic        pkt_dropped_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int frames, frame_hi, drops, stall_viol, first_cyc, drop_cyc;
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  logic prev_f = 1'b0;
  logic [7:0] prev_d = '0;

  usb_frame_packer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_sop_i      (in_sop),
    .in_eop_i      (in_eop),
    .in_abort_i    (in_abort),
    .rssi_i        (rssi),
    .channel_i     (channel),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .frame_o       (frame_o),
    .ready_i       (ready_i),
    .pkt_dropped_o (pkt_dropped_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer on the inactive edge: accepted words, frame starts, drop pulses, stall stability
  always @(negedge clk) begin
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (frame_o) frame_hi++;
    if (frame_o && !prev_f) begin
      frames++;
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (pkt_dropped_o) begin
      drops++;
      drop_cyc = cyc;
    end
    if (prev_v && !prev_r && (!valid_o || data_o !== prev_d)) stall_viol++;
    prev_v = valid_o;
    prev_r = ready_i;
    prev_f = frame_o;
    prev_d = data_o;
  end

  task automatic clear_mon();
    got_q.delete();
    frames = 0; frame_hi = 0; drops = 0; stall_viol = 0;
    first_cyc = -1; drop_cyc = -1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e,
                       input logic a, input logic [7:0] r, input logic [6:0] ch);
    in_valid = v; in_data = d; in_sop = s; in_eop = e; in_abort = a; rssi = r; channel = ch;
    @(posedge clk); #1;
  endtask

  task automatic quiet(input int n);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_abort = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    quiet(2);
    rst_i = 1'b1;
    quiet(1);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    quiet(2);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (frame_o !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_o); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_o); end
    checks++; if (pkt_dropped_o !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b exp=0", pkt_dropped_o); end
    checks++; if (drop_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_drop_cnt got=%h exp=0000", drop_cnt_o); end
    rst_i = 1'b1;
    quiet(2);
  endtask

  task automatic test_single();
    logic [7:0] exp_q[$];
    int eop_c;
    exp_q = '{8'h03, 8'hC4, 8'h25, 8'hA1, 8'hA2, 8'hA3};
    ready_i = 1'b1;
    clear_mon();
    drive(1, 8'hA1, 1, 0, 0, 8'hC4, 7'd37);
    drive(1, 8'hA2, 0, 0, 0, 8'h00, 7'd0);
    eop_c = cyc;
    drive(1, 8'hA3, 0, 1, 0, 8'h00, 7'd0);
    quiet(0);
    for (int k = 0; k < 50 && got_q.size() < 6; k++) begin @(posedge clk); #1; end
    quiet(3);
    checks++; if (got_q.size() != 6) begin failures++; $display("FAIL single_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (first_cyc != eop_c + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", first_cyc, eop_c + 2); end
    checks++; if (frame_hi != 3 + HDR_WORDS) begin failures++; $display("FAIL single_frame_cycles got=%0d exp=6", frame_hi); end
    checks++; if (frames != 1) begin failures++; $display("FAIL single_frames got=%0d exp=1", frames); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_q[$];
    exp_q = '{8'h03, 8'hC4, 8'h25, 8'hA1, 8'hA2, 8'hA3};
    ready_i = 1'b0;
    clear_mon();
    drive(1, 8'hA1, 1, 0, 0, 8'hC4, 7'd37);
    drive(1, 8'hA2, 0, 0, 0, 8'h00, 7'd0);
    drive(1, 8'hA3, 0, 1, 0, 8'h00, 7'd0);
    quiet(0);
    for (int k = 0; k < 40; k++) begin
      ready_i = ~ready_i;
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    quiet(3);
    checks++; if (got_q.size() != 6) begin failures++; $display("FAIL stall_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_stable got=%0d unstable_cycles exp=0", stall_viol); end
    checks++; if (frames != 1) begin failures++; $display("FAIL stall_frames got=%0d exp=1", frames); end
  endtask

  task automatic test_overlen();
    logic [7:0] exp_q[$];
    int eop_c;
    exp_q = '{8'h02, 8'h11, 8'h05, 8'h33, 8'h44};
    ready_i = 1'b1;
    clear_mon();
    eop_c = 0;
    for (int i = 0; i < 65; i++) begin
      if (i == 64) eop_c = cyc;
      drive(1, 8'(i), i == 0, i == 64, 0, 8'h77, 7'd3);
    end
    quiet(6);
    checks++; if (drops != 1) begin failures++; $display("FAIL overlen_pulses got=%0d exp=1", drops); end
    checks++; if (drop_cyc != eop_c + 1) begin failures++; $display("FAIL overlen_pulse_cycle got=%0d exp=%0d", drop_cyc, eop_c + 1); end
    checks++; if (drop_cnt_o !== 16'd1) begin failures++; $display("FAIL overlen_drop_cnt got=%0d exp=1", drop_cnt_o); end
    checks++; if (frames != 0) begin failures++; $display("FAIL overlen_frames got=%0d exp=0", frames); end
    clear_mon();
    drive(1, 8'h33, 1, 0, 0, 8'h11, 7'd5);
    drive(1, 8'h44, 0, 1, 0, 8'h00, 7'd0);
    quiet(0);
    for (int k = 0; k < 50 && got_q.size() < 5; k++) begin @(posedge clk); #1; end
    quiet(2);
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL after_drop_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL after_drop_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp_q[$];
    exp_q = '{8'h01, 8'h7F, 8'h12, 8'h5A};
    ready_i = 1'b1;
    clear_mon();
    for (int i = 0; i < 4; i++) drive(1, 8'(8'hB0 + i), i == 0, 0, 0, 8'h99, 7'd9);
    drive(0, 8'h00, 0, 0, 1, 8'h00, 7'd0);
    drive(1, 8'h5A, 1, 1, 0, 8'h7F, 7'h12);
    quiet(0);
    for (int k = 0; k < 50 && got_q.size() < 4; k++) begin @(posedge clk); #1; end
    quiet(4);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL abort_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (drops != 0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", drops); end
    checks++; if (drop_cnt_o !== 16'd1) begin failures++; $display("FAIL abort_drop_cnt got=%0d exp=1", drop_cnt_o); end
    checks++; if (frames != 1) begin failures++; $display("FAIL abort_frames got=%0d exp=1", frames); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_w;
    do_reset();
    ready_i = 1'b0;
    clear_mon();
    for (int i = 0; i < 9; i++) drive(1, 8'(8'h10 + i), 1, 1, 0, 8'(i), 7'(i));
    quiet(4);
    checks++; if (drops != 1) begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", drops); end
    checks++; if (drop_cnt_o !== 16'd1) begin failures++; $display("FAIL b2b_drop_cnt got=%0d exp=1", drop_cnt_o); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL b2b_stalled_words got=%0d exp=0", got_q.size()); end
    ready_i = 1'b1;
    for (int k = 0; k < 200 && got_q.size() < 32; k++) begin @(posedge clk); #1; end
    quiet(6);
    checks++; if (got_q.size() != 32) begin failures++; $display("FAIL b2b_count got=%0d exp=32", got_q.size()); end
    checks++; if (frames != 8) begin failures++; $display("FAIL b2b_frames got=%0d exp=8", frames); end
    for (int i = 0; i < 32 && i < got_q.size(); i++) begin
      case (i % 4)
        0:       exp_w = 8'h01;
        1, 2:    exp_w = 8'(i / 4);
        default: exp_w = 8'(8'h10 + i / 4);
      endcase
      checks++;
      if (got_q[i] !== exp_w) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got_q[i], exp_w); end
    end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) drive(1, 8'(8'h60 + i), i == 0, i == 9, 0, 8'h33, 7'h44);
    quiet(0);
    for (int k = 0; k < 50 && got_q.size() < 5; k++) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL midrst_progress got=%0d exp=5", got_q.size()); end
    rst_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid_o); end
    checks++; if (frame_o !== 1'b0) begin failures++; $display("FAIL midrst_frame got=%b exp=0", frame_o); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", data_o); end
    checks++; if (drop_cnt_o !== 16'h0) begin failures++; $display("FAIL midrst_drop_cnt got=%h exp=0000", drop_cnt_o); end
    @(posedge clk); #1;
    rst_i = 1'b1;
    clear_mon();
    quiet(20);
    checks++; if (frames != 0) begin failures++; $display("FAIL midrst_no_resume got=%0d frames exp=0", frames); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL midrst_no_words got=%0d exp=0", got_q.size()); end
  endtask

  initial begin
    clear_mon();
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_stall();
    test_overlen();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/usb_frame_packer.md
Name: usb_frame_packer

Overview:
- Parametrised output stage between the BLE packet analyser core and the USB interface.
- Buffers analysed packet words with commit/rollback so aborted packets never reach USB.
- Emits each committed packet as one USB frame: header words (length, RSSI, channel), then payload.
- Adds valid/ready backpressure on the USB side, plus drop accounting.

Parameters:
- DATA_W, 8, USB word width; must be >= max(RSSI_W, CHANNEL_W, LEN_W).
- RSSI_W, 8, RSSI field width.
- CHANNEL_W, 7, channel field width.
- MAX_LEN, 64, maximum payload words per packet.
- BUF_DEPTH, 256, payload buffer depth in words; power of 2, >= MAX_LEN.
- DESC_DEPTH, 8, committed-packet descriptor FIFO depth; power of 2.
- LEN_W (derived), clog2(MAX_LEN+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  payload word present.
- in_data_i  in  DATA_W  payload word.
- in_sop_i  in  1  first word of packet; qualified by in_valid_i.
- in_eop_i  in  1  last word of packet; qualified by in_valid_i.
- in_abort_i  in  1  discard open packet; not qualified by in_valid_i.
- rssi_i  in  RSSI_W  sampled with the sop word.
- channel_i  in  CHANNEL_W  sampled with the sop word.
- data_o  out  DATA_W  USB word.
- valid_o  out  1  data_o valid.
- frame_o  out  1  high on every word of a frame.
- ready_i  in  1  USB sink accepts word when valid_o && ready_i.
- pkt_dropped_o  out  1  one-cycle pulse per dropped packet.
- drop_cnt_o  out  16  saturating count of dropped packets.

Behaviour:
- Reset (rst_i low, async): data_o=0, valid_o=0, frame_o=0, pkt_dropped_o=0, drop_cnt_o=0; buffers flushed; FSM to IDLE.
- A reset mid-frame truncates the frame; no resumption.
- Input side is always ready; there is no in_ready.
- sop latches rssi_i/channel_i and records a rollback pointer.
- Each valid word is written speculatively; the word on the eop cycle is included.
- sop and eop in the same cycle is a 1-word packet.
- Commit at eop: speculative write pointer becomes visible, and a descriptor {len, rssi, channel} is pushed.
- Commit requires all of: len <= MAX_LEN, buffer not overflowed, descriptor FIFO not full. Otherwise the packet is dropped.
- Drop: write pointer rolls back, pkt_dropped_o pulses on the cycle after eop, drop_cnt_o increments (saturates at 16'hFFFF).
- in_abort_i or a new sop while a packet is open: silent rollback. No drop count. A new sop in the same cycle starts a fresh packet.
- Valid words with no open packet (no sop seen) are ignored.
- Output FSM states: IDLE, HDR_LEN, HDR_RSSI, HDR_CHAN, PAYLOAD.
- IDLE -> HDR_LEN when the descriptor FIFO is non-empty.
- Each header state advances on handshake; HDR_CHAN -> PAYLOAD.
- PAYLOAD counts down len words; on the last handshake it pops the descriptor and returns to IDLE.
- Header fields are zero-extended to DATA_W.
- valid_o and frame_o are high in all non-IDLE states; low in IDLE.
- frame_o is therefore low for at least one cycle between frames.
- data_o and valid_o stay stable while valid_o && !ready_i.
- Latency: eop at cycle N with idle output gives the length word on data_o at N+2. Frame length is len+3 words.
- Simultaneous commit and payload read in one cycle is legal; occupancy accounts for both.
- Buffer read/write pointers wrap modulo BUF_DEPTH.

Decomposition:
- Package ble_usb_pkg holds: FSM state enum, descriptor struct {len, rssi, channel}, header word-count constant (3), drop counter width (16).
- One sub-module: commit_fifo, a synchronous FIFO with speculative write pointer, commit and rollback. Used for the payload buffer.
- The descriptor FIFO is a plain instance of the same module with commit tied high every write.

Test Plan:
- Single packet, sop rssi=8'hC4 ch=7'd37, 3 words A1,A2,A3, ready_i=1 -> frame 03,C4,25,A1,A2,A3, frame_o high 6 cycles; length word at eop+2.
- Same packet with ready_i low on alternating cycles -> identical word sequence, data_o stable while stalled, no word lost or duplicated.
- Packet of MAX_LEN+1=65 words -> no frame, pkt_dropped_o one pulse, drop_cnt_o=1. A following 2-word packet is framed correctly.
- 4 words then in_abort_i, then a 1-word packet with sop+eop (data 5A) -> only frame 01,rssi,ch,5A; drop_cnt_o unchanged.
- 9 one-word packets back-to-back with ready_i=0 (DESC_DEPTH=8) -> 9th dropped, drop_cnt_o=1. Then ready_i=1 -> 8 frames, each separated by >=1 cycle with frame_o low.
- rst_i asserted during PAYLOAD of a 10-word frame -> all outputs 0 immediately, no further frame until new input.
